// File: rtl/alu_operand_stage.sv
// Purpose : operand-select and forwarding stage between decode and execute; resolves
//           rs1/rs2 against in-flight producers and stalls on load-use hazards.
// Latency : 1 cycle from capture (in_valid && in_ready) to out_valid; full throughput.
// Backpr. : holds registered outputs while out_valid && !out_ready; in_ready drops on
//           a hazard, a held output or reset.
//
// Ports:
//   clk, reset (sync, active-high), flush (kills held output and the input beat)
//   in_valid/in_ready + opcode, funct3, rs1, rs2, rs1_data, rs2_data, pc, imm12, u_imm20
//   fwd_valid/fwd_busy/fwd_rd/fwd_data : NUM_FWD producers, index 0 youngest
//   out_valid/out_ready + data0, data1, store_data, out_opcode, out_funct3
//   stall_cycles : only when ALU_OPERAND_STALL_CNT_EN is defined; saturating count of
//                  cycles with in_valid && hazard && !flush, cleared by reset only.
module alu_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic [XLEN-1:0]         rs1_data,
    input  logic [XLEN-1:0]         rs2_data,
    input  logic [XLEN-1:0]         pc,
    input  logic [11:0]             imm12,
    input  logic [19:0]             u_imm20,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_busy,
    input  logic [5*NUM_FWD-1:0]    fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         data0,
    output logic [XLEN-1:0]         data1,
    output logic [XLEN-1:0]         store_data,
    output logic [6:0]              out_opcode,
    output logic [2:0]              out_funct3
`ifdef ALU_OPERAND_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam int         SHW    = $clog2(XLEN);

    typedef struct packed {
        logic            busy;
        logic [XLEN-1:0] val;
    } src_t;

    // Walk oldest to youngest so the youngest matching producer overwrites the result.
    // A busy match still wins priority; its busy flag is what raises the hazard.
    function automatic src_t resolve(
        input logic [4:0]              rs,
        input logic [XLEN-1:0]         rf,
        input logic [NUM_FWD-1:0]      fv,
        input logic [NUM_FWD-1:0]      fb,
        input logic [5*NUM_FWD-1:0]    frd,
        input logic [XLEN*NUM_FWD-1:0] fdat
    );
        src_t r;
        r.busy = 1'b0;
        r.val  = rf;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fv[i] && (frd[i*5 +: 5] == rs)) begin
                r.busy = fb[i];
                r.val  = fdat[i*XLEN +: XLEN];
            end
        end
        if (rs == 5'd0) begin
            r.busy = 1'b0;
            r.val  = '0;
        end
        return r;
    endfunction

    src_t            src1, src2;
    logic            rs1_used, rs2_used, hazard, capture;
    logic [XLEN-1:0] imm, uimm, shamt;
    logic [XLEN-1:0] data0_d, data1_d;

    logic            out_valid_q;
    logic [XLEN-1:0] data0_q, data1_q, store_q;
    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;

    always_comb begin
        src1     = resolve(rs1, rs1_data, fwd_valid, fwd_busy, fwd_rd, fwd_data);
        src2     = resolve(rs2, rs2_data, fwd_valid, fwd_busy, fwd_rd, fwd_data);
        rs1_used = (opcode == OP_IMM) || (opcode == OP) || (opcode == LOAD) || (opcode == STORE);
        rs2_used = (opcode == OP) || (opcode == STORE);
        hazard   = (rs1_used && src1.busy) || (rs2_used && src2.busy);
        in_ready = !hazard && (!out_valid_q || out_ready) && !reset;
        capture  = in_valid && in_ready;
    end

    always_comb begin
        imm   = XLEN'($signed(imm12));
        uimm  = XLEN'($signed({u_imm20, 12'b0}));
        shamt = XLEN'(imm12[SHW-1:0]);

        data0_d = src1.val;
        if (opcode == AUIPC) begin
            data0_d = pc;
        end else if (opcode == LUI) begin
            data0_d = '0;
        end

        data1_d = src2.val;
        if ((opcode == LUI) || (opcode == AUIPC)) begin
            data1_d = uimm;
        end else if ((opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101))) begin
            data1_d = shamt;
        end else if ((opcode == OP_IMM) || (opcode == LOAD) || (opcode == STORE)) begin
            data1_d = imm;
        end
    end

    // Flush drops the held output and the incoming beat; reset additionally zeroes data.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
            store_q     <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            store_q     <= src2.val;
            opcode_q    <= opcode;
            funct3_q    <= funct3;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign data0      = data0_q;
    assign data1      = data1_q;
    assign store_data = store_q;
    assign out_opcode = opcode_q;
    assign out_funct3 = funct3_q;

`ifdef ALU_OPERAND_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (in_valid && hazard && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios then randomized traffic, with an
// expected-result queue filled at capture time and drained by an independent monitor.
module tb_alu_operand_stage;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [6:0]              opcode, out_opcode;
    logic [2:0]              funct3, out_funct3;
    logic [4:0]              rs1, rs2;
    logic [XLEN-1:0]         rs1_data, rs2_data, pc, data0, data1, store_data;
    logic [11:0]             imm12;
    logic [19:0]             u_imm20;
    logic [NUM_FWD-1:0]      fwd_valid, fwd_busy;
    logic [5*NUM_FWD-1:0]    fwd_rd;
    logic [XLEN*NUM_FWD-1:0] fwd_data;

    logic                    fv [NUM_FWD];
    logic                    fb [NUM_FWD];
    logic [4:0]              frd[NUM_FWD];
    logic [XLEN-1:0]         fd [NUM_FWD];

    for (genvar g = 0; g < NUM_FWD; g++) begin : g_pack
        assign fwd_valid[g]           = fv[g];
        assign fwd_busy[g]            = fb[g];
        assign fwd_rd[g*5 +: 5]       = frd[g];
        assign fwd_data[g*XLEN +: XLEN] = fd[g];
    end

`ifdef ALU_OPERAND_STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] exp_stall;
`endif

    alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc),
        .imm12(imm12), .u_imm20(u_imm20),
        .fwd_valid(fwd_valid), .fwd_busy(fwd_busy), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .data0(data0), .data1(data1), .store_data(store_data),
        .out_opcode(out_opcode), .out_funct3(out_funct3)
`ifdef ALU_OPERAND_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic [XLEN-1:0] d0, d1, sd;
        logic [6:0]      op;
        logic [2:0]      f3;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   started = 0;
    bit   exp_ov = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register value seen by an instruction: x0 is zero; otherwise the first (youngest)
    // producer naming the register supplies it, and tells us whether it is still busy.
    function automatic logic [XLEN-1:0] src_val(input logic [4:0] r, input logic [XLEN-1:0] rf,
                                               output bit busy);
        busy = 0;
        if (r == 0) return '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (fv[i] && frd[i] == r) begin
                busy = fb[i];
                return fd[i];
            end
        end
        return rf;
    endfunction

    function automatic void model(output exp_t e, output bit hz);
        bit              b1, b2, u1, u2;
        logic [XLEN-1:0] v1, v2, imm, uimm, sh;
        longint          s;
        v1 = src_val(rs1, rs1_data, b1);
        v2 = src_val(rs2, rs2_data, b2);
        s = longint'(imm12);
        if (s >= 2048) s -= 4096;
        imm = XLEN'(s);
        s = longint'(u_imm20);
        if (s >= 524288) s -= 1048576;
        uimm = XLEN'(s * 4096);
        sh   = XLEN'(imm12 % XLEN);
        u1 = (opcode == OP_IMM) || (opcode == OP) || (opcode == LOAD) || (opcode == STORE);
        u2 = (opcode == OP) || (opcode == STORE);
        hz = (u1 && b1) || (u2 && b2);
        case (opcode)
            AUIPC:   e.d0 = pc;
            LUI:     e.d0 = '0;
            default: e.d0 = v1;
        endcase
        if (opcode == LUI || opcode == AUIPC)                           e.d1 = uimm;
        else if (opcode == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101)) e.d1 = sh;
        else if (opcode == OP_IMM || opcode == LOAD || opcode == STORE) e.d1 = imm;
        else                                                            e.d1 = v2;
        e.sd = v2;
        e.op = opcode;
        e.f3 = funct3;
    endfunction

    // One clock: inputs already driven at the negedge; check handshake, record capture.
    task automatic cycle();
        exp_t e;
        bit   hz, ir, cap;
        #1;
        model(e, hz);
        ir = !reset && !hz && (!exp_ov || out_ready);
        chk("in_ready", in_ready, ir);
        chk("out_valid", out_valid, exp_ov);
`ifdef ALU_OPERAND_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, exp_stall);
        if (reset) exp_stall = 0;
        else if (in_valid && hz && !flush && exp_stall != 32'hFFFF_FFFF) exp_stall++;
`endif
        cap = in_valid && ir && !flush;
        if (cap) sb.push_back(e);
        if (reset || flush) exp_ov = 0;
        else if (cap)       exp_ov = 1;
        else if (out_ready) exp_ov = 0;
        @(negedge clk);
    endtask

    // Monitor: pops the expected entry whenever the DUT hands an operand set to execute.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (started) begin
            if (reset) begin
                sb.delete();
            end else if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: out_valid=1 with no outstanding capture at %0t", $time);
                end else if (flush) begin
                    void'(sb.pop_front());
                end else if (out_ready) begin
                    e = sb.pop_front();
                    chk("sb_data0", data0, e.d0);
                    chk("sb_data1", data1, e.d1);
                    chk("sb_store", store_data, e.sd);
                    chk("sb_opcode", out_opcode, e.op);
                    chk("sb_funct3", out_funct3, e.f3);
                end
            end
        end
    end

    task automatic idle();
        reset = 0; flush = 0; in_valid = 0; out_ready = 1;
        opcode = OP; funct3 = 0; rs1 = 0; rs2 = 0; rs1_data = 0; rs2_data = 0;
        pc = 0; imm12 = 0; u_imm20 = 0;
        for (int i = 0; i < NUM_FWD; i++) begin
            fv[i] = 0; fb[i] = 0; frd[i] = 0; fd[i] = 0;
        end
    endtask

    logic [6:0]      ops[7] = '{OP_IMM, OP, LOAD, STORE, AUIPC, LUI, BRANCH};
    logic [XLEN-1:0] held;
`ifdef ALU_OPERAND_STALL_CNT_EN
    logic [31:0]     stall_before;
`endif

    initial begin
        idle();
        reset = 1;
`ifdef ALU_OPERAND_STALL_CNT_EN
        exp_stall = 0;
`endif
        repeat (2) @(negedge clk);
        started = 1;
        cycle();
        chk("rst_data0", data0, 0);
        chk("rst_data1", data1, 0);
        chk("rst_store", store_data, 0);
        chk("rst_in_ready", in_ready, 0);

        // ADDI x5,x1,-4
        idle(); opcode = OP_IMM; rs1 = 1; rs1_data = 32'h10; imm12 = 12'hFFC; in_valid = 1;
        cycle();
        chk("addi_valid", out_valid, 1);
        chk("addi_data0", data0, 32'h10);
        chk("addi_data1", data1, 32'hFFFF_FFFC);

        // AUIPC / LUI
        idle(); opcode = AUIPC; pc = 32'h1000; u_imm20 = 20'h00012; in_valid = 1;
        cycle();
        chk("auipc_data0", data0, 32'h1000);
        chk("auipc_data1", data1, 32'h0001_2000);
        opcode = LUI;
        cycle();
        chk("lui_data0", data0, 0);
        chk("lui_data1", data1, 32'h0001_2000);

        // SLLI shamt takes log2(XLEN) bits of imm12
        idle(); opcode = OP_IMM; funct3 = 3'b001; rs1 = 1; imm12 = 12'h023; in_valid = 1;
        cycle();
        chk("slli_data1", data1, 3);

        // Forwarding priority and x0
        idle(); opcode = OP; rs1 = 1; rs2 = 2; rs1_data = 32'h11; rs2_data = 32'h22; in_valid = 1;
        fv[0] = 1; frd[0] = 1; fd[0] = 32'hAA; fv[1] = 1; frd[1] = 2; fd[1] = 32'hCC;
        cycle();
        chk("fwd_data0", data0, 32'hAA);
        chk("fwd_data1", data1, 32'hCC);
        frd[1] = 1; fd[1] = 32'hBB;
        cycle();
        chk("fwd_prio_data0", data0, 32'hAA);
        chk("fwd_rf_data1", data1, 32'h22);
        rs1 = 0; frd[0] = 0;
        cycle();
        chk("fwd_x0_data0", data0, 0);

        // Load-use stall on rs2 for three cycles, then forwarded value
`ifdef ALU_OPERAND_STALL_CNT_EN
        stall_before = stall_cycles;
`endif
        idle(); opcode = OP; rs1 = 3; rs2 = 2; in_valid = 1;
        fv[0] = 1; frd[0] = 2; fb[0] = 1; fd[0] = 32'h1;
        repeat (3) begin
            cycle();
            chk("lu_in_ready", in_ready, 0);
        end
        fb[0] = 0; fd[0] = 32'h55;
        cycle();
        chk("lu_data1", data1, 32'h55);
        chk("lu_store", store_data, 32'h55);
`ifdef ALU_OPERAND_STALL_CNT_EN
        chk("lu_stall_cycles", stall_cycles - stall_before, 3);
`endif

        // Backpressure hold, flush, reset mid-transfer
        idle(); cycle();
        opcode = OP_IMM; rs1 = 4; rs1_data = 32'h1234; imm12 = 12'h5; in_valid = 1; out_ready = 0;
        cycle();
        held = data0;
        chk("bp_capture", held, 32'h1234);
        rs1_data = 32'h9999;
        repeat (2) begin
            cycle();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", data0, held);
        end
        flush = 1;
        cycle();
        chk("flush_valid", out_valid, 0);
        flush = 0; in_valid = 0;
        cycle();
        chk("flush_drop", out_valid, 0);
        in_valid = 1;
        cycle();
        reset = 1;
        cycle();
        chk("rst_mid_valid", out_valid, 0);
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            opcode    = ops[$urandom_range(0, 6)];
            funct3    = 3'($urandom);
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            pc        = $urandom;
            imm12     = 12'($urandom);
            u_imm20   = 20'($urandom);
            for (int i = 0; i < NUM_FWD; i++) begin
                fv[i]  = ($urandom_range(0, 2) != 0);
                fb[i]  = ($urandom_range(0, 5) == 0);
                frd[i] = 5'($urandom_range(0, 7));
                fd[i]  = $urandom;
            end
            cycle();
        end

        idle();
        repeat (3) cycle();
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
